phy_rx_sync_ctrl: RTL and testbench

PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

---
 rtl/phy_rx_sync_ctrl.sv | 127 ++++++++++++
 tb/tb_phy_rx_sync_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_sync_ctrl.sv
// Two-lane serial receive byte aligner: hunts for a COMMA at any bit offset, confirms
// SYNC_CNT aligned COMMAs, then emits registered bytes at each byte boundary.
module phy_rx_sync_ctrl #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned SYNC_CNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic       in_0,
  input  logic       in_1,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       sync_0,
  output logic       sync_1
);

  localparam int unsigned CntW = (SYNC_CNT < 2) ? 1 : $clog2(SYNC_CNT + 1);

  typedef enum logic [1:0] {StSearch, StAlign, StActive} state_e;

  logic [1:0] in_v;
  logic [7:0] data_v  [2];
  logic [1:0] valid_v;
  logic [1:0] sync_v;

  assign in_v = {in_1, in_0};

  for (genvar g = 0; g < 2; g++) begin : gen_lane
    state_e          state_q, state_d;
    logic [7:0]      sr_q;
    logic [7:0]      word;
    logic [7:0]      data_q, data_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            boundary;

    assign word     = {sr_q[6:0], in_v[g]};
    assign boundary = (bit_cnt_q == 3'd7);

    always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      if (!enable) begin
        state_d   = StSearch;
        bit_cnt_d = '0;
        cnt_d     = '0;
        data_d    = '0;
        valid_d   = 1'b0;
      end else begin
        unique case (state_q)
          StSearch: begin
            data_d    = '0;
            valid_d   = 1'b0;
            bit_cnt_d = '0;
            cnt_d     = '0;
            if (word == COMMA) begin
              cnt_d   = CntW'(1);
              state_d = (SYNC_CNT <= 1) ? StActive : StAlign;
            end
          end
          StAlign: begin
            data_d    = '0;
            valid_d   = 1'b0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (boundary) begin
              if (word == COMMA) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CntW'(SYNC_CNT)) state_d = StActive;
              end else begin
                cnt_d   = '0;
                state_d = StSearch;
              end
            end
          end
          StActive: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (boundary) begin
              data_d  = word;
              valid_d = (word != COMMA);
            end
          end
          default: begin
            state_d = StSearch;
          end
        endcase
      end
    end

    // The shift register keeps running while disabled so re-acquisition sees real history.
    always_ff @(posedge clk_8f) begin
      if (!reset_L) begin
        state_q   <= StSearch;
        sr_q      <= '0;
        bit_cnt_q <= '0;
        cnt_q     <= '0;
        data_q    <= '0;
        valid_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        sr_q      <= word;
        bit_cnt_q <= bit_cnt_d;
        cnt_q     <= cnt_d;
        data_q    <= data_d;
        valid_q   <= valid_d;
      end
    end

    assign data_v[g]  = data_q;
    assign valid_v[g] = valid_q;
    assign sync_v[g]  = (state_q == StActive);
  end

  assign data_out_0  = data_v[0];
  assign data_out_1  = data_v[1];
  assign valid_out_0 = valid_v[0];
  assign valid_out_1 = valid_v[1];
  assign sync_0      = sync_v[0];
  assign sync_1      = sync_v[1];

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Bench for phy_rx_sync_ctrl: per-edge comparison against a lock-position model, plus
// directed literal checks on the key protocol events.
module tb_phy_rx_sync_ctrl;

  localparam logic [7:0] BC = 8'hBC;

  logic       clk_8f = 1'b0;
  logic       reset_L;
  logic       enable;
  logic       in_0;
  logic       in_1;
  logic [7:0] data_out_0, data_out_1;
  logic       valid_out_0, valid_out_1;
  logic       sync_0, sync_1;

  phy_rx_sync_ctrl dut (
    .clk_8f      (clk_8f),
    .reset_L     (reset_L),
    .enable      (enable),
    .in_0        (in_0),
    .in_1        (in_1),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .sync_0      (sync_0),
    .sync_1      (sync_1)
  );

  always #5 clk_8f = ~clk_8f;

  int n_checks = 0;
  int n_errors = 0;
  logic sync0_seen;

  // Model: a lane is either hunting, confirming or locked; once a match is found at edge t0,
  // byte boundaries are the edges t0+8k.
  logic [7:0] m_hist  [2];
  logic [7:0] m_data  [2];
  logic       m_valid [2];
  int         m_mode  [2];
  int         m_ncom  [2];
  int         m_since [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int l, input logic b);
    logic [7:0] win;
    win = {m_hist[l][6:0], b};
    if (!reset_L) begin
      m_hist[l] = '0;
      m_mode[l] = 0;
      m_ncom[l] = 0;
    end else begin
      m_hist[l] = win;
      if (!enable) begin
        m_mode[l] = 0;
        m_ncom[l] = 0;
      end else if (m_mode[l] == 0) begin
        if (win == BC) begin
          m_mode[l]  = 1;
          m_ncom[l]  = 1;
          m_since[l] = 0;
        end
      end else begin
        m_since[l]++;
        if (m_since[l] % 8 == 0) begin
          if (m_mode[l] == 1) begin
            if (win == BC) begin
              m_ncom[l]++;
              if (m_ncom[l] == 4) m_mode[l] = 2;
            end else begin
              m_mode[l] = 0;
              m_ncom[l] = 0;
            end
          end else begin
            m_data[l]  = win;
            m_valid[l] = (win != BC);
          end
        end
      end
    end
    if (m_mode[l] != 2 || m_since[l] % 8 == 0 && m_mode[l] == 2 && m_since[l] == 0) begin
      m_data[l]  = '0;
      m_valid[l] = 1'b0;
    end
  endtask

  task automatic tick(input logic b0, input logic b1);
    in_0 = b0;
    in_1 = b1;
    model_step(0, b0);
    model_step(1, b1);
    @(posedge clk_8f);
    #1;
    chk("data_out_0",  32'(data_out_0),  32'(m_data[0]));
    chk("valid_out_0", 32'(valid_out_0), 32'(m_valid[0]));
    chk("sync_0",      32'(sync_0),      32'(m_mode[0] == 2));
    chk("data_out_1",  32'(data_out_1),  32'(m_data[1]));
    chk("valid_out_1", 32'(valid_out_1), 32'(m_valid[1]));
    chk("sync_1",      32'(sync_1),      32'(m_mode[1] == 2));
    if (sync_0) sync0_seen = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 7; i >= 0; i--) tick(b0[i], b1[i]);
  endtask

  logic [7:0] seq [6];

  initial begin
    for (int l = 0; l < 2; l++) begin
      m_hist[l] = '0; m_data[l] = '0; m_valid[l] = 1'b0;
      m_mode[l] = 0;  m_ncom[l] = 0;  m_since[l] = 0;
    end
    sync0_seen = 1'b0;
    reset_L = 1'b0;
    enable  = 1'b1;
    in_0    = 1'b1;
    in_1    = 1'b1;

    // Reset held for 8 edges with ones on the lines.
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
    chk("rst_sync_0", 32'(sync_0), 32'd0);
    chk("rst_data_0", 32'(data_out_0), 32'd0);

    // Lock both lanes, then FF / 00.
    reset_L = 1'b1;
    for (int k = 0; k < 4; k++) send_byte(BC, BC);
    chk("lock_sync_0", 32'(sync_0), 32'd1);
    chk("lock_sync_1", 32'(sync_1), 32'd1);
    chk("lock_valid_0", 32'(valid_out_0), 32'd0);
    send_byte(8'hFF, 8'h00);
    chk("ff_data_0",  32'(data_out_0),  32'hFF);
    chk("ff_valid_0", 32'(valid_out_0), 32'd1);
    chk("00_data_1",  32'(data_out_1),  32'h00);
    chk("00_valid_1", 32'(valid_out_1), 32'd1);

    // Data stream with an embedded COMMA.
    seq[0] = 8'hEE; seq[1] = 8'hEE; seq[2] = 8'hDD;
    seq[3] = 8'hDD; seq[4] = BC;    seq[5] = 8'hAA;
    for (int k = 0; k < 6; k++) begin
      send_byte(seq[k], seq[k]);
      if (k == 2) chk("dd_data_0", 32'(data_out_0), 32'hDD);
      if (k == 4) begin
        chk("bc_valid_0", 32'(valid_out_0), 32'd0);
        chk("bc_data_0",  32'(data_out_0),  32'hBC);
        chk("bc_sync_0",  32'(sync_0),      32'd1);
      end
    end
    chk("aa_data_1",  32'(data_out_1),  32'hAA);
    chk("aa_valid_1", 32'(valid_out_1), 32'd1);

    // One-edge enable drop while locked.
    enable = 1'b0;
    tick(1'b0, 1'b0);
    chk("dis_sync_0", 32'(sync_0), 32'd0);
    chk("dis_data_1", 32'(data_out_1), 32'd0);
    enable = 1'b1;

    // Junk bits then re-lock at offset 3.
    tick(1'b1, 1'b1); tick(1'b0, 1'b0); tick(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(BC, BC);
    chk("relock_sync_0", 32'(sync_0), 32'd1);
    send_byte(8'h5A, 8'hA5);
    chk("off3_data_0", 32'(data_out_0), 32'h5A);
    chk("off3_data_1", 32'(data_out_1), 32'hA5);

    // Reset pulse in ACTIVE, then lane 0 fails on 55 while lane 1 locks.
    reset_L = 1'b0;
    tick(1'b1, 1'b1);
    chk("rstp_sync_1", 32'(sync_1), 32'd0);
    reset_L = 1'b1;
    sync0_seen = 1'b0;
    for (int k = 0; k < 3; k++) send_byte(BC, BC);
    send_byte(8'h55, BC);
    chk("fail_sync_0", 32'(sync_0), 32'd0);
    chk("ok_sync_1",   32'(sync_1), 32'd1);
    send_byte(8'h55, 8'h3C);
    chk("never_sync_0", 32'(sync0_seen), 32'd0);
    chk("ind_data_1",   32'(data_out_1), 32'h3C);

    // Enable low coinciding with a COMMA match, then reset and enable low together.
    for (int i = 7; i >= 1; i--) tick(BC[i], BC[i]);
    enable = 1'b0;
    tick(BC[0], BC[0]);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(BC, BC);
    chk("en_wins_sync_0", 32'(sync_0), 32'd0);
    reset_L = 1'b0;
    enable  = 1'b0;
    tick(1'b0, 1'b0);
    reset_L = 1'b1;
    enable  = 1'b1;
    for (int k = 0; k < 4; k++) send_byte(BC, BC);
    send_byte(8'h12, 8'h34);
    chk("final_data_0", 32'(data_out_0), 32'h12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
